ssdt_echo: RTL and testbench

SSDT echo responder: the far end of the SSDT valid/data stream. It accepts words on the `in_valid`/`in_data` side, buffers them in a FIFO, and returns them on `out_valid`/`out_data` at a paced rate with an optional XOR transform. The SSDT UVC uses it as a real sequential DUT in place of the back-to-back dummy, so driver-to-monitor checks see buffering, latency, pacing and drop behaviour.

---
 rtl/ssdt_echo.sv | 92 +++++++++
 tb/tb_ssdt_echo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ssdt_echo.sv
// ssdt_echo: far end of an SSDT valid/data stream.
// Incoming words go into a circular FIFO with no backpressure. They are
// returned in order at a paced rate, XORed with a fixed mask on the way out.
// A word that arrives while the FIFO is full and nothing leaves on that edge
// is dropped, and the sticky overflow flag is set.
module ssdt_echo #(
  parameter int              DATA_W   = 4,
  parameter int              DEPTH    = 8,
  parameter int              GAP      = 0,
  parameter logic [DATA_W-1:0] XOR_MASK = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] fill_level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [3:0]    GAP_LD   = 4'(GAP);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]     count_reg, count_next;
  logic [3:0]        gap_cnt_reg, gap_cnt_next;

  logic pop, push, drop, full;

  // Handshake decisions are made from pre-edge state. A pop on the same edge
  // frees a slot, so a full FIFO still accepts a word when it is also popping.
  always_comb begin
    full = (count_reg == FULL_CNT);
    pop  = (count_reg != '0) && (gap_cnt_reg == 4'd0);
    push = in_valid && (!full || pop);
    drop = in_valid && full && !pop;
  end

  // Compute the next occupancy and pacing counter.
  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + 1'b1;
    else if (pop && !push)
      count_next = count_reg - 1'b1;

    gap_cnt_next = gap_cnt_reg;
    if (pop)
      gap_cnt_next = GAP_LD;
    else if (gap_cnt_reg != 4'd0)
      gap_cnt_next = gap_cnt_reg - 4'd1;
  end

  // Storage array: it has no reset. Stale contents are unreachable after
  // reset because the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push && !rst)
      mem[wr_ptr_reg] <= in_data;
  end

  // Update pointers, count, pacing and the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      gap_cnt_reg <= 4'd0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      overflow    <= 1'b0;
    end else begin
      count_reg   <= count_next;
      gap_cnt_reg <= gap_cnt_next;
      out_valid   <= pop;
      if (pop) begin
        out_data   <= mem[rd_ptr_reg] ^ XOR_MASK;
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (drop)
        overflow <= 1'b1;
    end
  end

  assign fill_level = count_reg;

endmodule

// File: tb/tb_ssdt_echo.sv
// Directed testbench for ssdt_echo. It uses three instances that share the
// clock, reset and input stream:
//   d0: GAP=0, XOR_MASK=0
//   d1: GAP=0, XOR_MASK=F
//   d3: GAP=3, XOR_MASK=0
module tb_ssdt_echo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic       in_valid = 1'b0;

  logic       d0_ov_valid, d1_ov_valid, d3_ov_valid;
  logic [3:0] d0_data, d1_data, d3_data;
  logic       d0_ovf, d1_ovf, d3_ovf;
  logic [3:0] d0_fill, d1_fill, d3_fill;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ssdt_echo #(.DATA_W(4), .DEPTH(8), .GAP(0), .XOR_MASK(4'h0)) d0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_valid(d0_ov_valid), .out_data(d0_data), .overflow(d0_ovf), .fill_level(d0_fill));

  ssdt_echo #(.DATA_W(4), .DEPTH(8), .GAP(0), .XOR_MASK(4'hF)) d1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_valid(d1_ov_valid), .out_data(d1_data), .overflow(d1_ovf), .fill_level(d1_fill));

  ssdt_echo #(.DATA_W(4), .DEPTH(8), .GAP(3), .XOR_MASK(4'h0)) d3 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_valid(d3_ov_valid), .out_data(d3_data), .overflow(d3_ovf), .fill_level(d3_fill));

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply reset for two edges. Reset is released mid-cycle, and the next
  // rising edge is "edge 1".
  task automatic reset_all();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (d0_ov_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", d0_ov_valid); else pass_cnt++;
    total_cnt++; if (d0_data !== 4'h0) $display("FAIL reset_out_data got %h want 0", d0_data); else pass_cnt++;
    total_cnt++; if (d0_ovf !== 1'b0) $display("FAIL reset_overflow got %b want 0", d0_ovf); else pass_cnt++;
    total_cnt++; if (d0_fill !== 4'd0) $display("FAIL reset_fill got %0d want 0", d0_fill); else pass_cnt++;
    total_cnt++; if (d3_fill !== 4'd0) $display("FAIL reset_fill_d3 got %0d want 0", d3_fill); else pass_cnt++;
    $display("reset: out_valid=%b out_data=%h overflow=%b fill=%0d", d0_ov_valid, d0_data, d0_ovf, d0_fill);
  endtask

  task automatic test_single_word();
    reset_all();
    in_valid = 1'b1; in_data = 4'hA;
    tick(); // edge N
    in_valid = 1'b0;
    total_cnt++; if (d0_ov_valid !== 1'b0) $display("FAIL single_valid_N got %b want 0", d0_ov_valid); else pass_cnt++;
    total_cnt++; if (d0_fill !== 4'd1) $display("FAIL single_fill_N got %0d want 1", d0_fill); else pass_cnt++;
    tick(); // edge N+1
    total_cnt++; if (d0_ov_valid !== 1'b1) $display("FAIL single_valid_N1 got %b want 1", d0_ov_valid); else pass_cnt++;
    total_cnt++; if (d0_data !== 4'hA) $display("FAIL single_data got %h want a", d0_data); else pass_cnt++;
    total_cnt++; if (d0_fill !== 4'd0) $display("FAIL single_fill_N1 got %0d want 0", d0_fill); else pass_cnt++;
    $display("single: out word %h", d0_data);
    tick();
    total_cnt++; if (d0_ov_valid !== 1'b0) $display("FAIL single_valid_N2 got %b want 0", d0_ov_valid); else pass_cnt++;
    total_cnt++; if (d0_data !== 4'hA) $display("FAIL single_data_hold got %h want a", d0_data); else pass_cnt++;
  endtask

  task automatic test_burst_xor();
    logic [3:0] exp;
    reset_all();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      tick();
      if (i > 0) begin
        exp = 4'(i - 1) ^ 4'hF;
        total_cnt++; if (d1_ov_valid !== 1'b1) $display("FAIL burst_valid[%0d] got %b want 1", i, d1_ov_valid); else pass_cnt++;
        total_cnt++; if (d1_data !== exp) $display("FAIL burst_data[%0d] got %h want %h", i, d1_data, exp); else pass_cnt++;
        $display("burst: out word %h", d1_data);
      end
      total_cnt++; if (d1_fill !== 4'd1) $display("FAIL burst_fill[%0d] got %0d want 1", i, d1_fill); else pass_cnt++;
    end
    in_valid = 1'b0;
    tick();
    total_cnt++; if (d1_ov_valid !== 1'b1) $display("FAIL burst_valid_last got %b want 1", d1_ov_valid); else pass_cnt++;
    total_cnt++; if (d1_data !== 4'h8) $display("FAIL burst_data_last got %h want 8", d1_data); else pass_cnt++;
    total_cnt++; if (d1_fill !== 4'd0) $display("FAIL burst_fill_end got %0d want 0", d1_fill); else pass_cnt++;
    total_cnt++; if (d1_ovf !== 1'b0) $display("FAIL burst_overflow got %b want 0", d1_ovf); else pass_cnt++;
  endtask

  // GAP=3 with 16 continuous words. Pops occur at edges 2,6,...,46.
  // Words 11, 12, 14 and 15 are dropped.
  task automatic test_pacing_overflow();
    logic [3:0] exp_data [12];
    logic [3:0] fill_tab [16];
    logic       exp_v;
    int         widx;
    int         seen;
    exp_data = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd13};
    fill_tab = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd5, 4'd6,
                 4'd7, 4'd7, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8};
    widx = 0;
    seen = 0;
    reset_all();
    for (int k = 1; k <= 50; k++) begin
      in_valid = (k <= 16);
      in_data = 4'(k - 1);
      tick();
      exp_v = (k >= 2) && (k <= 46) && (((k - 2) % 4) == 0);
      total_cnt++; if (d3_ov_valid !== exp_v) $display("FAIL pace_valid[e%0d] got %b want %b", k, d3_ov_valid, exp_v); else pass_cnt++;
      if (d3_ov_valid === 1'b1) seen++;
      if (exp_v && widx < 12) begin
        total_cnt++; if (d3_data !== exp_data[widx]) $display("FAIL pace_data[%0d] got %h want %h", widx, d3_data, exp_data[widx]); else pass_cnt++;
        $display("pace: edge %0d out word %h", k, d3_data);
        widx++;
      end
      if (k <= 16) begin
        total_cnt++; if (d3_fill !== fill_tab[k-1]) $display("FAIL pace_fill[e%0d] got %0d want %0d", k, d3_fill, fill_tab[k-1]); else pass_cnt++;
      end
      if (k == 11 || k == 12 || k == 50) begin
        total_cnt++; if (d3_ovf !== (k >= 12)) $display("FAIL pace_overflow[e%0d] got %b want %b", k, d3_ovf, (k >= 12)); else pass_cnt++;
      end
    end
    total_cnt++; if (seen != 12) $display("FAIL pace_emit_count got %0d want 12", seen); else pass_cnt++;
    total_cnt++; if (d3_fill !== 4'd0) $display("FAIL pace_fill_drained got %0d want 0", d3_fill); else pass_cnt++;
  endtask

  // Fill to 8 (words 0..10 at edges 1..11), then go idle. At edge 14,
  // gap_cnt is 0, so 0xC is pushed while a pop happens on the same edge.
  task automatic test_full_pop();
    reset_all();
    for (int k = 1; k <= 50; k++) begin
      in_valid = (k <= 11) || (k == 14);
      in_data = (k <= 11) ? 4'(k - 1) : 4'hC;
      tick();
      if (k == 11 || k == 13) begin
        total_cnt++; if (d3_fill !== 4'd8) $display("FAIL fullpop_fill[e%0d] got %0d want 8", k, d3_fill); else pass_cnt++;
      end
      if (k == 14) begin
        total_cnt++; if (d3_fill !== 4'd8) $display("FAIL fullpop_fill_e14 got %0d want 8", d3_fill); else pass_cnt++;
        total_cnt++; if (d3_ovf !== 1'b0) $display("FAIL fullpop_overflow got %b want 0", d3_ovf); else pass_cnt++;
        total_cnt++; if (d3_data !== 4'h3) $display("FAIL fullpop_head got %h want 3", d3_data); else pass_cnt++;
      end
      if (k == 46) begin
        total_cnt++; if (d3_ov_valid !== 1'b1) $display("FAIL fullpop_c_valid got %b want 1", d3_ov_valid); else pass_cnt++;
        total_cnt++; if (d3_data !== 4'hC) $display("FAIL fullpop_c_data got %h want c", d3_data); else pass_cnt++;
        $display("fullpop: edge %0d out word %h", k, d3_data);
      end
    end
    total_cnt++; if (d3_fill !== 4'd0) $display("FAIL fullpop_drained got %0d want 0", d3_fill); else pass_cnt++;
    total_cnt++; if (d3_ovf !== 1'b0) $display("FAIL fullpop_overflow_end got %b want 0", d3_ovf); else pass_cnt++;
  endtask

  // Buffer 5 words in d3, pulse reset between edges, then send 0x3.
  task automatic test_reset_mid();
    reset_all();
    for (int k = 1; k <= 7; k++) begin
      in_valid = 1'b1;
      in_data = 4'(8 + k - 1);
      tick();
    end
    in_valid = 1'b0;
    total_cnt++; if (d3_fill !== 4'd5) $display("FAIL rmid_fill_before got %0d want 5", d3_fill); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (d3_fill !== 4'd0) $display("FAIL rmid_fill_async got %0d want 0", d3_fill); else pass_cnt++;
    total_cnt++; if (d3_ov_valid !== 1'b0) $display("FAIL rmid_valid_async got %b want 0", d3_ov_valid); else pass_cnt++;
    #2 rst = 1'b0;
    in_valid = 1'b1; in_data = 4'h3;
    tick();
    in_valid = 1'b0;
    total_cnt++; if (d3_fill !== 4'd1) $display("FAIL rmid_fill_push got %0d want 1", d3_fill); else pass_cnt++;
    total_cnt++; if (d3_ov_valid !== 1'b0) $display("FAIL rmid_valid_N got %b want 0", d3_ov_valid); else pass_cnt++;
    tick();
    total_cnt++; if (d3_ov_valid !== 1'b1) $display("FAIL rmid_valid_N1 got %b want 1", d3_ov_valid); else pass_cnt++;
    total_cnt++; if (d3_data !== 4'h3) $display("FAIL rmid_data got %h want 3", d3_data); else pass_cnt++;
    $display("rmid: out word %h", d3_data);
    for (int k = 0; k < 8; k++) begin
      tick();
      total_cnt++; if (d3_ov_valid !== 1'b0) $display("FAIL rmid_stale[%0d] got %b want 0 (data %h)", k, d3_ov_valid, d3_data); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_burst_xor();
    test_pacing_overflow();
    test_full_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
